// File: rtl/sumnb_serial_if.sv
// Operand/result bundle for the serial adder: request side drives start and operands,
// the adder answers with busy/done and the registered result.
// No flow control beyond start/busy/done; the adder ignores start while busy.
interface sumnb_serial_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Ci;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             V;

  modport master (
    output start, A, B, Ci,
    input  busy, done, S, Cout, V
  );

  modport slave (
    input  start, A, B, Ci,
    output busy, done, S, Cout, V
  );
endinterface

// File: rtl/sumnb_serial.sv
// Multi-cycle WIDTH-bit adder: STEP bits per clock, LSB chunk first, registered carry.
// Latency N = WIDTH/STEP cycles from the accepting edge to the done pulse.
// start is sampled only in IDLE; requests while busy are dropped, outputs hold the last result.
module sumnb_serial #(
  parameter int WIDTH = 8,
  parameter int STEP  = 1
) (
  input logic           clk,
  input logic           rst_n,
  sumnb_serial_if.slave bus
);
  localparam int N  = WIDTH / STEP;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, psum_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             carry_q, busy_q, done_q, cout_q, v_q;

  logic [STEP:0]    chunk_sum;
  logic [WIDTH-1:0] psum_d;
  logic             last_chunk;
  logic             msb_carry_in;

  // One STEP-bit full-adder slice on the low chunk of the shifting operands.
  always_comb begin
    chunk_sum    = {1'b0, a_q[STEP-1:0]} + {1'b0, b_q[STEP-1:0]} + {{STEP{1'b0}}, carry_q};
    // New chunk enters at the top so that after N chunks the LSB chunk sits at bit 0.
    psum_d       = WIDTH'({chunk_sum[STEP-1:0], psum_q} >> STEP);
    last_chunk   = (cnt_q == CW'(N - 1));
    // On the last chunk its top bit is the result MSB; the carry into it is recovered
    // from the operand bits and the sum bit.
    msb_carry_in = a_q[STEP-1] ^ b_q[STEP-1] ^ chunk_sum[STEP-1];
  end

  // Control FSM plus datapath registers; results are only written on the completion edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            carry_q <= bus.Ci;
            psum_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q     <= a_q >> STEP;
          b_q     <= b_q >> STEP;
          psum_q  <= psum_d;
          carry_q <= chunk_sum[STEP];
          cnt_q   <= cnt_q + CW'(1);
          if (last_chunk) begin
            s_q     <= psum_d;
            cout_q  <= chunk_sum[STEP];
            v_q     <= msb_carry_in ^ chunk_sum[STEP];
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.S    = s_q;
  assign bus.Cout = cout_q;
  assign bus.V    = v_q;
endmodule

// File: tb/tb_sumnb_serial.sv
// Bench for sumnb_serial: three instances (8/1, 8/4, 4/2) driven from one clock and reset.
// Directed vector table, back-to-back and abort-by-reset sequences, random and exhaustive runs
// checked against an arithmetic reference model.
module tb_sumnb_serial;
  logic clk;
  logic rst_n;

  logic       st [3];
  logic [7:0] at [3];
  logic [7:0] bt [3];
  logic       ct [3];
  logic       bsy[3];
  logic       dn [3];
  logic [7:0] so [3];
  logic       co [3];
  logic       vo [3];

  int W[3] = '{8, 8, 4};
  int N[3] = '{8, 2, 2};

  int checks = 0;
  int errors = 0;

  sumnb_serial_if #(.WIDTH(8)) if0 ();
  sumnb_serial_if #(.WIDTH(8)) if1 ();
  sumnb_serial_if #(.WIDTH(4)) if2 ();

  sumnb_serial #(.WIDTH(8), .STEP(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
  sumnb_serial #(.WIDTH(8), .STEP(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
  sumnb_serial #(.WIDTH(4), .STEP(2)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

  assign if0.start = st[0];
  assign if0.A     = at[0];
  assign if0.B     = bt[0];
  assign if0.Ci    = ct[0];
  assign if1.start = st[1];
  assign if1.A     = at[1];
  assign if1.B     = bt[1];
  assign if1.Ci    = ct[1];
  assign if2.start = st[2];
  assign if2.A     = at[2][3:0];
  assign if2.B     = bt[2][3:0];
  assign if2.Ci    = ct[2];

  assign bsy[0] = if0.busy;
  assign dn[0]  = if0.done;
  assign so[0]  = if0.S;
  assign co[0]  = if0.Cout;
  assign vo[0]  = if0.V;
  assign bsy[1] = if1.busy;
  assign dn[1]  = if1.done;
  assign so[1]  = if1.S;
  assign co[1]  = if1.Cout;
  assign vo[1]  = if1.V;
  assign bsy[2] = if2.busy;
  assign dn[2]  = if2.done;
  assign so[2]  = {4'b0000, if2.S};
  assign co[2]  = if2.Cout;
  assign vo[2]  = if2.V;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {V, Cout, S}.
  function automatic logic [9:0] model(input int w, input logic [7:0] a, input logic [7:0] b,
                                       input logic ci);
    int ua, ub, sa, sb, sum, ss, s;
    logic cout, v;
    ua   = int'(a) & ((1 << w) - 1);
    ub   = int'(b) & ((1 << w) - 1);
    sum  = ua + ub + int'(ci);
    s    = sum % (1 << w);
    cout = (sum >= (1 << w));
    sa   = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb   = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    ss   = sa + sb + int'(ci);
    v    = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
    return {v, cout, s[7:0]};
  endfunction

  task automatic rnd_in(input int d);
    logic [7:0] m;
    m = 8'((1 << W[d]) - 1);
    at[d] = 8'($urandom) & m;
    bt[d] = 8'($urandom) & m;
    ct[d] = 1'($urandom);
  endtask

  // Waits for done after an accepting edge; checks latency, hold-during-run and result.
  task automatic wait_done(input int d, input logic [7:0] es, input logic ec, input logic ev,
                           input logic [7:0] prev_s, input string nm);
    int cyc = 0;
    bit seen = 0;
    bit run_ok = 1;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (dn[d]) seen = 1;
      else begin
        if (bsy[d] !== 1'b1 || so[d] !== prev_s) run_ok = 0;
        rnd_in(d);
      end
    end
    chk({nm, " latency"}, cyc, N[d]);
    chk({nm, " busy/S held in run"}, int'(run_ok), 1);
    chk({nm, " S"}, int'(so[d]), int'(es));
    chk({nm, " Cout"}, int'(co[d]), int'(ec));
    chk({nm, " V"}, int'(vo[d]), int'(ev));
    chk({nm, " busy in done cycle"}, int'(bsy[d]), 0);
  endtask

  task automatic op(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci,
                    input logic [7:0] es, input logic ec, input logic ev, input bit hold,
                    input string nm);
    logic [7:0] prev_s;
    logic [9:0] m2;
    prev_s = so[d];
    @(negedge clk);
    st[d] = 1'b1;
    at[d] = a;
    bt[d] = b;
    ct[d] = ci;
    @(posedge clk);
    #1;
    if (!hold) st[d] = 1'b0;
    rnd_in(d);
    wait_done(d, es, ec, ev, prev_s, nm);
    if (hold) begin
      // start never dropped: the operands now on the bus are taken at the next edge
      prev_s = so[d];
      m2 = model(W[d], at[d], bt[d], ct[d]);
      @(posedge clk);
      #1;
      chk({nm, " b2b done pulse"}, int'(dn[d]), 0);
      chk({nm, " b2b accepted"}, int'(bsy[d]), 1);
      st[d] = 1'b0;
      rnd_in(d);
      wait_done(d, m2[7:0], m2[8], m2[9], prev_s, {nm, " b2b"});
    end
    @(posedge clk);
    #1;
    chk({nm, " done pulse"}, int'(dn[d]), 0);
  endtask

  typedef struct {
    int         d;
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] s;
    logic       c;
    logic       v;
    bit         hold;
  } vec_t;

  vec_t vt[8];

  initial begin
    logic [9:0] m;
    bit seen;

    vt[0] = '{0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[1] = '{0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vt[2] = '{0, 8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
    vt[3] = '{1, 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
    vt[4] = '{2, 8'h07, 8'h01, 1'b0, 8'h08, 1'b0, 1'b1, 1'b0};
    vt[5] = '{2, 8'h0F, 8'h0F, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
    vt[6] = '{0, 8'h3C, 8'h41, 1'b1, 8'h7E, 1'b0, 1'b0, 1'b1};
    vt[7] = '{1, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      at[i] = 8'h00;
      bt[i] = 8'h00;
      ct[i] = 1'b0;
    end
    rst_n = 1'b0;
    #12;
    chk("reset busy", int'(bsy[0]), 0);
    chk("reset done", int'(dn[0]), 0);
    chk("reset S", int'(so[0]), 0);
    chk("reset Cout", int'(co[0]), 0);
    chk("reset V", int'(vo[0]), 0);
    chk("reset S w4", int'(so[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++)
      op(vt[i].d, vt[i].a, vt[i].b, vt[i].ci, vt[i].s, vt[i].c, vt[i].v, vt[i].hold,
         $sformatf("vec%0d", i));

    // Abort mid-run by reset, then confirm a clean restart.
    op(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0, "pre-reset");
    @(negedge clk);
    st[0] = 1'b1;
    at[0] = 8'hF0;
    bt[0] = 8'h0F;
    ct[0] = 1'b0;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort busy", int'(bsy[0]), 0);
    chk("abort done", int'(dn[0]), 0);
    chk("abort S", int'(so[0]), 0);
    chk("abort Cout", int'(co[0]), 0);
    chk("abort V", int'(vo[0]), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (dn[0] || bsy[0]) seen = 1;
    end
    chk("no done after abort", int'(seen), 0);
    op(0, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, "post-reset");

    // Start held high through the run on both 8-bit configurations.
    m = model(8, 8'h6D, 8'h93, 1'b0);
    op(0, 8'h6D, 8'h93, 1'b0, m[7:0], m[8], m[9], 1'b1, "hold8x1");
    m = model(8, 8'hC4, 8'hB7, 1'b1);
    op(1, 8'hC4, 8'hB7, 1'b1, m[7:0], m[8], m[9], 1'b1, "hold8x4");

    // Random operands against the reference model.
    for (int i = 0; i < 40; i++) begin
      int d;
      logic [7:0] a, b;
      logic ci;
      d  = i % 2;
      a  = 8'($urandom);
      b  = 8'($urandom);
      ci = 1'($urandom);
      m  = model(8, a, b, ci);
      op(d, a, b, ci, m[7:0], m[8], m[9], 1'($urandom_range(0, 3) == 0),
         $sformatf("rnd%0d", i));
    end

    // Exhaustive 4-bit sweep.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          m = model(4, 8'(a), 8'(b), 1'(c));
          op(2, 8'(a), 8'(b), 1'(c), m[7:0], m[8], m[9], 1'b0,
             $sformatf("ex a=%0h b=%0h ci=%0d", a, b, c));
        end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
